// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the 8-bit datapath/memory.
// The master side (sequencer) drives every load/select/ALU control and the
// memory write strobe; it observes the instruction register and CCR flags.
interface control_unit_if;
   logic [7:0] IR;
   logic [3:0] CCR_Result;   // {N,Z,V,C}
   logic       IR_Load;
   logic       MAR_Load;
   logic       PC_Load;
   logic       PC_Inc;
   logic       A_Load;
   logic       B_Load;
   logic       CCR_Load;
   logic [1:0] Bus1_Sel;     // 00 PC, 01 A, 10 B
   logic [1:0] Bus2_Sel;     // 00 ALU, 01 Bus1, 10 from_memory
   logic [2:0] ALU_Sel;      // 000 ADD, 010 SUB
   logic       write;

   modport master (
      input  IR, CCR_Result,
      output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
             Bus1_Sel, Bus2_Sel, ALU_Sel, write
   );

   modport slave (
      output IR, CCR_Result,
      input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
             Bus1_Sel, Bus2_Sel, ALU_Sel, write
   );
endinterface

// File: rtl/control_unit.sv
// Fetch-decode-execute sequencer for the 8-bit CPU datapath.
// Moore machine: every control output is a registered function of the state
// it accompanies, so the output register is loaded with the decode of the
// next state. Operand fetch (MAR<-PC, PC++) and the direct-address step are
// shared by all instructions that need them; later states pick the path by
// the (stable) IR. Only BEQ looks at the Z flag, and only in decode.
module control_unit (
   input  logic                 Clk,
   input  logic                 Reset,   // async, active low
   control_unit_if.master       bus
);

   localparam logic [7:0] OP_LDA_IMM = 8'h86;
   localparam logic [7:0] OP_LDA_DIR = 8'h87;
   localparam logic [7:0] OP_LDB_IMM = 8'h88;
   localparam logic [7:0] OP_LDB_DIR = 8'h89;
   localparam logic [7:0] OP_STA_DIR = 8'h96;
   localparam logic [7:0] OP_STB_DIR = 8'h97;
   localparam logic [7:0] OP_ADD_AB  = 8'h42;
   localparam logic [7:0] OP_SUB_AB  = 8'h43;
   localparam logic [7:0] OP_BRA     = 8'h20;
   localparam logic [7:0] OP_BEQ     = 8'h23;

   typedef enum logic [4:0] {
      S_FETCH_0   = 5'd0,
      S_FETCH_1   = 5'd1,
      S_FETCH_2   = 5'd2,
      S_DECODE_3  = 5'd3,
      S_OPA_4     = 5'd4,   // MAR <- PC (operand address)
      S_OPA_5     = 5'd5,   // PC++
      S_LDA_IMM_6 = 5'd6,
      S_LDB_IMM_6 = 5'd7,
      S_DIR_6     = 5'd8,   // MAR <- operand (direct address)
      S_LD_DIR_7  = 5'd9,   // wait for memory read
      S_LDA_DIR_8 = 5'd10,
      S_LDB_DIR_8 = 5'd11,
      S_STA_DIR_7 = 5'd12,
      S_STB_DIR_7 = 5'd13,
      S_ADD_AB_4  = 5'd14,
      S_SUB_AB_4  = 5'd15,
      S_BRA_4     = 5'd16,  // MAR <- PC (target address)
      S_BRA_5     = 5'd17,  // wait for memory read
      S_BRA_6     = 5'd18,  // PC <- target
      S_BEQ_NT_4  = 5'd19   // branch not taken: skip operand
   } state_t;

   typedef struct packed {
      logic       ir_load;
      logic       mar_load;
      logic       pc_load;
      logic       pc_inc;
      logic       a_load;
      logic       b_load;
      logic       ccr_load;
      logic [1:0] bus1_sel;
      logic [1:0] bus2_sel;
      logic [2:0] alu_sel;
      logic       write;
   } ctrl_t;

   state_t r_state;
   ctrl_t  r_ctrl;
   state_t w_next;

   // Next-state function; unknown opcodes and unused encodings fall to fetch.
   function automatic state_t f_next(input state_t s, input logic [7:0] ir, input logic z);
      state_t n;
      n = S_FETCH_0;
      case (s)
         S_FETCH_0: n = S_FETCH_1;
         S_FETCH_1: n = S_FETCH_2;
         S_FETCH_2: n = S_DECODE_3;
         S_DECODE_3:
            case (ir)
               OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR,
               OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: n = S_OPA_4;
               OP_ADD_AB: n = S_ADD_AB_4;
               OP_SUB_AB: n = S_SUB_AB_4;
               OP_BRA:    n = S_BRA_4;
               OP_BEQ:    n = z ? S_BRA_4 : S_BEQ_NT_4;
               default:   n = S_FETCH_0;
            endcase
         S_OPA_4: n = S_OPA_5;
         S_OPA_5:
            case (ir)
               OP_LDA_IMM: n = S_LDA_IMM_6;
               OP_LDB_IMM: n = S_LDB_IMM_6;
               OP_LDA_DIR, OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: n = S_DIR_6;
               default:    n = S_FETCH_0;
            endcase
         S_DIR_6:
            case (ir)
               OP_LDA_DIR, OP_LDB_DIR: n = S_LD_DIR_7;
               OP_STA_DIR: n = S_STA_DIR_7;
               OP_STB_DIR: n = S_STB_DIR_7;
               default:    n = S_FETCH_0;
            endcase
         S_LD_DIR_7: n = (ir == OP_LDB_DIR) ? S_LDB_DIR_8 : S_LDA_DIR_8;
         S_BRA_4:    n = S_BRA_5;
         S_BRA_5:    n = S_BRA_6;
         default:    n = S_FETCH_0;
      endcase
      return n;
   endfunction

   // Output decode for a state; everything defaults to 0 / PC / ALU / ADD.
   function automatic ctrl_t f_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH_0, S_OPA_4, S_BRA_4: begin
            c.bus1_sel = 2'b00;
            c.bus2_sel = 2'b01;
            c.mar_load = 1'b1;
         end
         S_FETCH_1, S_OPA_5, S_BEQ_NT_4: c.pc_inc = 1'b1;
         S_FETCH_2: begin
            c.bus2_sel = 2'b10;
            c.ir_load  = 1'b1;
         end
         S_LDA_IMM_6, S_LDA_DIR_8: begin
            c.bus2_sel = 2'b10;
            c.a_load   = 1'b1;
         end
         S_LDB_IMM_6, S_LDB_DIR_8: begin
            c.bus2_sel = 2'b10;
            c.b_load   = 1'b1;
         end
         S_DIR_6: begin
            c.bus2_sel = 2'b10;
            c.mar_load = 1'b1;
         end
         S_STA_DIR_7: begin
            c.bus1_sel = 2'b01;
            c.write    = 1'b1;
         end
         S_STB_DIR_7: begin
            c.bus1_sel = 2'b10;
            c.write    = 1'b1;
         end
         S_ADD_AB_4, S_SUB_AB_4: begin
            c.bus1_sel = 2'b01;
            c.bus2_sel = 2'b00;
            c.alu_sel  = (s == S_SUB_AB_4) ? 3'b010 : 3'b000;
            c.a_load   = 1'b1;
            c.ccr_load = 1'b1;
         end
         S_BRA_6: begin
            c.bus2_sel = 2'b10;
            c.pc_load  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign w_next = f_next(r_state, bus.IR, bus.CCR_Result[2]);

   // State register plus registered decode of the state being entered.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_FETCH_0;
         r_ctrl  <= f_ctrl(S_FETCH_0);
      end else begin
         r_state <= w_next;
         r_ctrl  <= f_ctrl(w_next);
      end
   end

   assign bus.IR_Load  = r_ctrl.ir_load;
   assign bus.MAR_Load = r_ctrl.mar_load;
   assign bus.PC_Load  = r_ctrl.pc_load;
   assign bus.PC_Inc   = r_ctrl.pc_inc;
   assign bus.A_Load   = r_ctrl.a_load;
   assign bus.B_Load   = r_ctrl.b_load;
   assign bus.CCR_Load = r_ctrl.ccr_load;
   assign bus.Bus1_Sel = r_ctrl.bus1_sel;
   assign bus.Bus2_Sel = r_ctrl.bus2_sel;
   assign bus.ALU_Sel  = r_ctrl.alu_sel;
   assign bus.write    = r_ctrl.write;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small behavioural datapath and synchronous-read
// memory close the loop so whole programs run; expected register, PC, flag
// and memory values are hand-computed constants.
module tb_control_unit;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   control_unit_if cu_if ();

   control_unit u_dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (cu_if)
   );

   // ---------------- datapath + memory model ----------------
   logic [7:0] pc, mar, ir_q, a, b, from_mem;
   logic [3:0] ccr;
   logic [7:0] mem [0:255];
   logic [7:0] bus1, bus2, alu_r;
   logic [3:0] nzvc;
   logic [8:0] wide;

   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = '0, ld_data = '0;
   int         wr_cnt = 0;
   logic [7:0] wr_addr = '0, wr_data = '0;

   assign cu_if.IR         = ir_q;
   assign cu_if.CCR_Result = ccr;

   always_comb begin
      bus1 = 8'h00;
      case (cu_if.Bus1_Sel)
         2'b00: bus1 = pc;
         2'b01: bus1 = a;
         2'b10: bus1 = b;
         default: bus1 = 8'h00;
      endcase
      wide = 9'h000;
      nzvc = 4'h0;
      if (cu_if.ALU_Sel == 3'b010) begin
         wide    = {1'b0, b} - {1'b0, bus1};
         nzvc[1] = (b[7] != bus1[7]) && (wide[7] != b[7]);
      end else begin
         wide    = {1'b0, b} + {1'b0, bus1};
         nzvc[1] = (b[7] == bus1[7]) && (wide[7] != b[7]);
      end
      alu_r   = wide[7:0];
      nzvc[3] = alu_r[7];
      nzvc[2] = (alu_r == 8'h00);
      nzvc[0] = wide[8];
      bus2 = alu_r;
      case (cu_if.Bus2_Sel)
         2'b01: bus2 = bus1;
         2'b10: bus2 = from_mem;
         default: bus2 = alu_r;
      endcase
   end

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc <= 8'h00; mar <= 8'h00; ir_q <= 8'h00;
         a <= 8'h00; b <= 8'h00; ccr <= 4'h0; from_mem <= 8'h00;
      end else begin
         if (cu_if.IR_Load)  ir_q <= bus2;
         if (cu_if.MAR_Load) mar  <= bus2;
         if (cu_if.PC_Load)  pc   <= bus2;
         else if (cu_if.PC_Inc) pc <= pc + 8'h01;
         if (cu_if.A_Load)   a    <= bus2;
         if (cu_if.B_Load)   b    <= bus2;
         if (cu_if.CCR_Load) ccr  <= nzvc;
         from_mem <= mem[mar];
      end
   end

   // Memory writes: bench loader has priority, CPU stores are logged.
   always @(posedge Clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (Reset && cu_if.write) begin
         mem[mar] <= bus1;
         wr_cnt   <= wr_cnt + 1;
         wr_addr  <= mar;
         wr_data  <= bus1;
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   wire [6:0] en = {cu_if.IR_Load, cu_if.MAR_Load, cu_if.PC_Load, cu_if.PC_Inc,
                    cu_if.A_Load, cu_if.B_Load, cu_if.CCR_Load};

   task automatic run(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic poke(input logic [7:0] ad, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = ad; ld_data = d;
      @(negedge Clk);
      ld_en = 1'b0;
   endtask

   logic [7:0] prog [0:24];
   initial begin
      prog = '{8'h86, 8'hAA, 8'h88, 8'h55, 8'h42, 8'h96, 8'hE0,
               8'h86, 8'h33, 8'h88, 8'h33, 8'h43, 8'h23, 8'h10,
               8'h00, 8'h00,
               8'h88, 8'h00, 8'h86, 8'h01, 8'h42, 8'h23, 8'h10, 8'h20, 8'h40};

      // Load memory while the CPU is held in reset.
      @(negedge Clk);
      for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
      for (int i = 0; i < 25; i++) poke(i[7:0], prog[i]);
      poke(8'h40, 8'hFF);
      poke(8'h41, 8'h87); poke(8'h42, 8'hE0);
      poke(8'h43, 8'h96); poke(8'h44, 8'hE8);

      // Reset held: S_FETCH_0 outputs.
      run(2);
      chk("rst_enables", en, 7'b0100000);
      chk("rst_write", cu_if.write, 1'b0);
      chk("rst_alu", cu_if.ALU_Sel, 3'b000);

      Reset = 1'b1;
      run(2);
      chk("ir_load_3rd", cu_if.IR_Load, 1'b1);
      run(1);
      chk("ir_fetched", ir_q, 8'h86);
      run(4);
      chk("lda_imm_a", a, 8'hAA);
      chk("lda_imm_pc", pc, 8'h02);
      run(7);
      chk("ldb_imm_b", b, 8'h55);
      run(5);
      chk("add_a", a, 8'hFF);
      chk("add_n", ccr[3], 1'b1);
      chk("add_z", ccr[2], 1'b0);
      run(8);
      chk("sta_wr_cnt", wr_cnt, 1);
      chk("sta_addr", wr_addr, 8'hE0);
      chk("sta_data", wr_data, 8'hFF);
      chk("sta_pc", pc, 8'h07);

      // A=B=0x33, SUB -> zero
      run(19);
      chk("sub_a", a, 8'h00);
      chk("sub_z", ccr[2], 1'b1);
      run(7);
      chk("beq_taken_pc", pc, 8'h10);

      // B=0, A=1, ADD -> Z=0, then BEQ not taken
      run(19);
      chk("add2_a", a, 8'h01);
      chk("add2_z", ccr[2], 1'b0);
      run(5);
      chk("beq_nt_pc", pc, 8'h17);
      run(7);
      chk("bra_pc", pc, 8'h40);

      // Illegal opcode at 0x40; mem[E0] reloaded during its fetch.
      poke(8'hE0, 8'h5A);
      run(2);
      chk("ill_decode_en", en, 7'b0000000);
      chk("ill_ir", ir_q, 8'hFF);
      run(1);
      chk("ill_pc", pc, 8'h41);
      chk("ill_refetch_en", en, 7'b0100000);
      run(9);
      chk("lda_dir_a", a, 8'h5A);
      chk("lda_dir_pc", pc, 8'h43);

      // STA_DIR 0xE8 aborted by reset in the MAR<-from_memory state.
      run(6);
      chk("sta_dir6_en", en, 7'b0100000);
      chk("sta_dir6_bus2", cu_if.Bus2_Sel, 2'b10);
      Reset = 1'b0;
      run(2);
      chk("abort_enables", en, 7'b0100000);
      chk("abort_write", cu_if.write, 1'b0);
      Reset = 1'b1;
      run(2);
      chk("restart_ir_load", cu_if.IR_Load, 1'b1);
      run(1);
      chk("restart_ir", ir_q, 8'h86);
      run(4);
      chk("abort_wr_cnt", wr_cnt, 1);
      chk("abort_mem_e8", mem[8'hE8], 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
